// File: rtl/param_multicycle_control_unit_if.sv
// Control-unit bus bundle: instruction/data inputs from ROM, register file, ALU and
// data memory, plus the control word and status driven back to the datapath.
// The master modport is the control unit; the slave modport is the datapath side.
interface param_multicycle_control_unit_if #(
    parameter int unsigned PC_WIDTH   = 6,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned INSTR_W = 4 + 3 * REG_ADDR_W;

    logic [INSTR_W-1:0]    instruction;
    logic [DATA_WIDTH-1:0] A_bus;
    logic                  Z;
    logic                  mem_ready;
    logic [PC_WIDTH-1:0]   PC;
    logic [REG_ADDR_W-1:0] DR;
    logic [REG_ADDR_W-1:0] SA;
    logic [REG_ADDR_W-1:0] SB;
    logic [3:0]            FS;
    logic                  MB;
    logic                  MD;
    logic                  RW;
    logic                  MM;
    logic                  MW;
    logic                  mem_req;
    logic                  halted;

    modport master (
        input  instruction, A_bus, Z, mem_ready,
        output PC, DR, SA, SB, FS, MB, MD, RW, MM, MW, mem_req, halted
    );

    modport slave (
        output instruction, A_bus, Z, mem_ready,
        input  PC, DR, SA, SB, FS, MB, MD, RW, MM, MW, mem_req, halted
    );
endinterface

// File: rtl/param_multicycle_control_unit.sv
// Multicycle control unit: PC, IR, FETCH/EXEC/MEM/HALT sequencer and decoder.
// Control outputs are an unregistered decode of state and IR.
// Optional return-address stack (CALL/RET on opcode E) enabled by CU_CALL_STACK_EN.
module param_multicycle_control_unit #(
    parameter int unsigned PC_WIDTH   = 6,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    param_multicycle_control_unit_if.master cu
);
    localparam int unsigned INSTR_W = 4 + 3 * REG_ADDR_W;
    localparam int unsigned OffW    = 2 * REG_ADDR_W;
    localparam int unsigned ExtW    = (OffW > PC_WIDTH) ? OffW : PC_WIDTH;

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;

    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] dr, sa, sb;
    logic                  is_ld, is_st;

    assign opcode = ir_q[INSTR_W-1 -: 4];
    assign dr     = ir_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign sa     = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign sb     = ir_q[REG_ADDR_W-1:0];
    assign is_ld  = (opcode == 4'h8);
    assign is_st  = (opcode == 4'h9);

    assign cu.DR = dr;
    assign cu.SA = sa;
    assign cu.SB = sb;
    assign cu.PC = pc_q;

    // PC-relative target: {DR,SB} is signed, extended (or truncated) to the PC width
    logic signed [OffW-1:0] br_off;
    logic signed [ExtW-1:0] br_ext;
    logic [PC_WIDTH-1:0]    pc_br, pc_inc, pc_jmp;

    assign br_off = {dr, sb};
    assign br_ext = ExtW'(br_off);
    assign pc_br  = pc_q + br_ext[PC_WIDTH-1:0];
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign pc_jmp = cu.A_bus[PC_WIDTH-1:0];

`ifdef CU_CALL_STACK_EN
    logic [PC_WIDTH-1:0] stack_q [4];
    logic [2:0]          sp_q, sp_d;
    logic                push;
    logic [1:0]          top_idx;

    assign top_idx = sp_q[1:0] - 2'd1;

    // Return-address storage; only the pointer needs a reset value
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[1:0]] <= pc_inc;
        end
    end

    // Stack pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= 3'd0;
        end else begin
            sp_q <= sp_d;
        end
    end
`endif

    // State, PC and IR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Sequencer next-state and control-word decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cu.FS      = 4'h0;
        cu.MB      = 1'b0;
        cu.MD      = 1'b0;
        cu.RW      = 1'b0;
        cu.MM      = 1'b0;
        cu.MW      = 1'b0;
        cu.mem_req = 1'b0;
        cu.halted  = 1'b0;
`ifdef CU_CALL_STACK_EN
        sp_d       = sp_q;
        push       = 1'b0;
`endif
        unique case (state_q)
            StFetch: begin
                ir_d    = cu.instruction;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_inc;
                unique case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        cu.FS = {1'b0, opcode[2:0]};
                        cu.RW = 1'b1;
                    end
                    4'h8, 4'h9: begin
                        pc_d    = pc_q;
                        state_d = StMem;
                    end
                    4'hA: if (cu.Z)  pc_d = pc_br;
                    4'hB: if (!cu.Z) pc_d = pc_br;
                    4'hC: pc_d = pc_jmp;
                    4'hD: begin
                        cu.MB = 1'b1;
                        cu.RW = 1'b1;
                    end
                    4'hE: begin
`ifdef CU_CALL_STACK_EN
                        // Overflow/underflow halts with the pointer left untouched
                        if (!dr[0]) begin
                            if (sp_q == 3'd4) begin
                                pc_d    = pc_q;
                                state_d = StHalt;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + 3'd1;
                                pc_d = pc_jmp;
                            end
                        end else begin
                            if (sp_q == 3'd0) begin
                                pc_d    = pc_q;
                                state_d = StHalt;
                            end else begin
                                sp_d = sp_q - 3'd1;
                                pc_d = stack_q[top_idx];
                            end
                        end
`endif
                    end
                    4'hF: begin
                        pc_d    = pc_q;
                        state_d = StHalt;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                cu.mem_req = 1'b1;
                cu.MM      = 1'b1;
                cu.MW      = is_st;
                cu.MD      = is_ld;
                if (cu.mem_ready) begin
                    cu.RW   = is_ld;
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                cu.halted = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
